cbfp_norm_stage: RTL and testbench

CBFP_NORM_STAGE -- requirements
Module: cbfp_norm_stage

---
 rtl/cbfp_norm_stage.sv | 178 +++++++++++++++++
 tb/tb_cbfp_norm_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_norm_stage.sv
// cbfp_norm_stage
//   Convergent block-floating-point normalizer. Collects BLK beats of N complex
//   lanes into one bank of a ping-pong buffer while tracking the smallest count
//   of redundant sign bits over the whole block. When the last beat lands, the
//   block shift is latched and the banks swap; the filled bank then drains as
//   BLK output beats, each sample left-shifted by the block shift, rounded and
//   saturated down to OUT_W bits.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   valid_in            : input beat valid
//   real_in / imag_in   : N signed IN_W-bit lane samples
//   flush               : discard any partial block
//   bypass              : force shift 0 for the block (sampled on its last beat)
//   valid_out, sop_out  : output beat valid, first beat of an output block
//   real_out / imag_out : N signed OUT_W-bit normalized samples
//   index_out           : block shift, held for all BLK beats of the block
module cbfp_norm_stage #(
  parameter int IN_W   = 25,
  parameter int OUT_W  = 12,
  parameter int N      = 16,
  parameter int BLK    = 4,
  parameter int MAX_SH = IN_W - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  real_in   [0:N-1],
  input  logic signed [IN_W-1:0]  imag_in   [0:N-1],
  input  logic                    flush,
  input  logic                    bypass,
  output logic                    valid_out,
  output logic                    sop_out,
  output logic signed [OUT_W-1:0] real_out  [0:N-1],
  output logic signed [OUT_W-1:0] imag_out  [0:N-1],
  output logic [$clog2(IN_W)-1:0] index_out
);

  localparam int SW = $clog2(IN_W);
  localparam int CW = $clog2(BLK);
  localparam int D  = IN_W - OUT_W;

  localparam logic [SW-1:0]        LZ_MAX = SW'(IN_W - 1);
  localparam logic [SW-1:0]        SH_CAP = SW'(MAX_SH);
  localparam logic [CW-1:0]        LAST   = CW'(BLK - 1);
  localparam logic signed [IN_W:0] RND    = (IN_W+1)'(1 << (D - 1));
  localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(-(1 << (OUT_W - 1)));

  typedef enum logic {S_IDLE, S_DRAIN} drain_state_t;

  // Redundant sign bits: leading bits equal to the MSB, not counting the MSB.
  function automatic logic [SW-1:0] lz(input logic signed [IN_W-1:0] x);
    logic [SW-1:0] c;
    logic          run;
    c   = '0;
    run = 1'b1;
    for (int unsigned i = 1; i < IN_W; i++) begin
      if (run && (x[IN_W-1-i] == x[IN_W-1])) c = c + SW'(1);
      else                                   run = 1'b0;
    end
    return c;
  endfunction

  // The shift never exceeds the block's headroom, so x <<< s fits in IN_W
  // bits; one extra bit absorbs the rounding carry before saturation.
  function automatic logic signed [OUT_W-1:0] norm(input logic signed [IN_W-1:0] x,
                                                   input logic [SW-1:0] s);
    logic signed [IN_W:0] t;
    logic signed [IN_W:0] r;
    t = {x[IN_W-1], x};
    t = t <<< s;
    t = t + RND;
    r = t >>> D;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    return r[OUT_W-1:0];
  endfunction

  logic signed [IN_W-1:0] mem_re [0:1][0:BLK-1][0:N-1];
  logic signed [IN_W-1:0] mem_im [0:1][0:BLK-1][0:N-1];

  logic [CW-1:0] cnt;
  logic [SW-1:0] run_min;
  logic          fill_bank;
  logic          rd_bank;
  logic [SW-1:0] beat_min, base_min, blk_min, shift_new;
  logic [CW-1:0] wr_beat;
  logic          last_beat;

  drain_state_t  state_q, state_d;
  logic [CW-1:0] drain_idx;
  logic [SW-1:0] drain_s;

  always_comb begin
    beat_min = LZ_MAX;
    for (int unsigned i = 0; i < N; i++) begin
      if (lz(real_in[i]) < beat_min) beat_min = lz(real_in[i]);
      if (lz(imag_in[i]) < beat_min) beat_min = lz(imag_in[i]);
    end
    // A flushing beat starts a fresh block, so it ignores the old running min.
    base_min  = flush ? LZ_MAX : run_min;
    blk_min   = (beat_min < base_min) ? beat_min : base_min;
    shift_new = bypass ? '0 : ((blk_min < SH_CAP) ? blk_min : SH_CAP);
    wr_beat   = flush ? '0 : cnt;
    last_beat = valid_in && !flush && (cnt == LAST);
    rd_bank   = ~fill_bank;
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem_re[fill_bank][wr_beat][i] <= real_in[i];
        mem_im[fill_bank][wr_beat][i] <= imag_in[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      run_min   <= LZ_MAX;
      fill_bank <= 1'b0;
    end else if (valid_in) begin
      if (last_beat) begin
        cnt       <= '0;
        run_min   <= LZ_MAX;
        fill_bank <= ~fill_bank;
      end else begin
        cnt     <= flush ? CW'(1) : cnt + CW'(1);
        run_min <= blk_min;
      end
    end else if (flush) begin
      cnt     <= '0;
      run_min <= LZ_MAX;
    end
  end

  // A new block can only complete on the same edge as the previous drain's
  // final beat, so restarting the drain there never cuts a block short.
  always_comb begin
    state_d = state_q;
    if (last_beat)                                     state_d = S_DRAIN;
    else if (state_q == S_DRAIN && drain_idx == LAST)  state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      drain_idx <= '0;
      drain_s   <= '0;
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      index_out <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        real_out[i] <= '0;
        imag_out[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      valid_out <= (state_q == S_DRAIN);
      sop_out   <= (state_q == S_DRAIN) && (drain_idx == '0);
      if (state_q == S_DRAIN) begin
        index_out <= drain_s;
        for (int unsigned i = 0; i < N; i++) begin
          real_out[i] <= norm(mem_re[rd_bank][drain_idx][i], drain_s);
          imag_out[i] <= norm(mem_im[rd_bank][drain_idx][i], drain_s);
        end
        drain_idx <= drain_idx + CW'(1);
      end
      if (last_beat) begin
        drain_idx <= '0;
        drain_s   <= shift_new;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_norm_stage.sv
// tb_cbfp_norm_stage
//   Directed bench for cbfp_norm_stage at IN_W=25, OUT_W=12, N=16, BLK=4.
//   Expected sample values and shifts are hand-computed constants.
module tb_cbfp_norm_stage;

  localparam int IN_W  = 25;
  localparam int OUT_W = 12;
  localparam int N     = 16;
  localparam int BLK   = 4;
  localparam int SW    = $clog2(IN_W);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_in;
  logic signed [IN_W-1:0]  real_in  [0:N-1];
  logic signed [IN_W-1:0]  imag_in  [0:N-1];
  logic                    flush;
  logic                    bypass;
  logic                    valid_out;
  logic                    sop_out;
  logic signed [OUT_W-1:0] real_out [0:N-1];
  logic signed [OUT_W-1:0] imag_out [0:N-1];
  logic [SW-1:0]           index_out;

  int checks = 0;
  int errors = 0;

  int in_re  [BLK][N];
  int in_im  [BLK][N];
  int exp_re [BLK][N];
  int exp_im [BLK][N];

  always #5 clk = ~clk;

  cbfp_norm_stage #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .N     (N),
    .BLK   (BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .real_in   (real_in),
    .imag_in   (imag_in),
    .flush     (flush),
    .bypass    (bypass),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .real_out  (real_out),
    .imag_out  (imag_out),
    .index_out (index_out)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern(input int v, input int e);
    for (int b = 0; b < BLK; b++)
      for (int i = 0; i < N; i++) begin
        in_re[b][i] = v;  in_im[b][i] = v;
        exp_re[b][i] = e; exp_im[b][i] = e;
      end
  endtask

  task automatic set_beat(input int b);
    for (int i = 0; i < N; i++) begin
      real_in[i] = IN_W'(in_re[b][i]);
      imag_in[i] = IN_W'(in_im[b][i]);
    end
    valid_in = 1'b1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) begin
      real_in[i] = IN_W'(v);
      imag_in[i] = IN_W'(v);
    end
    valid_in = 1'b1;
  endtask

  task automatic send_block(input logic byp);
    for (int b = 0; b < BLK; b++) begin
      set_beat(b);
      bypass = (b == BLK - 1) ? byp : 1'b0;
      tick();
    end
    valid_in = 1'b0;
    bypass   = 1'b0;
    chk("no_out_on_last_edge", valid_out, 0);
  endtask

  task automatic check_drain(input string tag, input int idx);
    for (int j = 0; j < BLK; j++) begin
      tick();
      chk($sformatf("%s_b%0d_valid", tag, j), valid_out, 1);
      chk($sformatf("%s_b%0d_sop", tag, j), sop_out, (j == 0) ? 1 : 0);
      chk($sformatf("%s_b%0d_index", tag, j), index_out, idx);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("%s_b%0d_re%0d", tag, j, i), real_out[i], exp_re[j][i]);
        chk($sformatf("%s_b%0d_im%0d", tag, j, i), imag_out[i], exp_im[j][i]);
      end
    end
    tick();
    chk({tag, "_end_valid"}, valid_out, 0);
    chk({tag, "_hold_re"}, real_out[0], exp_re[BLK-1][0]);
    chk({tag, "_hold_im"}, imag_out[N-1], exp_im[BLK-1][N-1]);
    chk({tag, "_hold_index"}, index_out, idx);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; bypass = 1'b0;
    set_all(0);
    valid_in = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_sop", sop_out, 0);
    chk("rst_index", index_out, 0);
    chk("rst_re0", real_out[0], 0);
    chk("rst_im15", imag_out[N-1], 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // All ones: headroom 23, (2^23 + 2^12) >> 13 = 1024
    fill_pattern(1, 1024);
    send_block(1'b0);
    check_drain("ones", 23);

    // Full-scale negative plus a small value: no headroom
    fill_pattern(0, 0);
    in_re[0][0] = -16777216; exp_re[0][0] = -2048;
    in_im[2][3] = 4095;      exp_im[2][3] = 0;
    send_block(1'b0);
    check_drain("mixed", 0);

    // Positive full scale rounds up past the range and saturates
    fill_pattern(0, 0);
    in_re[1][2] = 16777215; exp_re[1][2] = 2047;
    send_block(1'b0);
    check_drain("sat", 0);
    send_block(1'b1);
    check_drain("sat_byp", 0);

    // Bypass on small values: shift 0, (1 + 2^12) >> 13 = 0
    fill_pattern(1, 0);
    send_block(1'b1);
    check_drain("byp_ones", 0);

    // All -1: maximal headroom 24, -2^24 rounds to -2048
    fill_pattern(-1, -2048);
    send_block(1'b0);
    check_drain("neg_one", 24);

    // Eight continuous beats: ones (shift 23 -> 1024) then 1000 (shift 14 -> 2000)
    for (int e = 0; e < 12; e++) begin
      if (e < 4)      set_all(1);
      else if (e < 8) set_all(1000);
      else            valid_in = 1'b0;
      tick();
      if (e < 4) begin
        chk($sformatf("cont_e%0d_valid", e), valid_out, 0);
      end else begin
        chk($sformatf("cont_e%0d_valid", e), valid_out, 1);
        chk($sformatf("cont_e%0d_sop", e), sop_out, ((e - 4) % 4 == 0) ? 1 : 0);
        chk($sformatf("cont_e%0d_index", e), index_out, (e < 8) ? 23 : 14);
        chk($sformatf("cont_e%0d_re0", e), real_out[0], (e < 8) ? 1024 : 2000);
        chk($sformatf("cont_e%0d_im15", e), imag_out[N-1], (e < 8) ? 1024 : 2000);
      end
    end
    tick();
    chk("cont_end_valid", valid_out, 0);

    // Two beats, idle flush, then a full block of ones
    fill_pattern(5, 0);
    set_beat(0); tick();
    set_beat(1); tick();
    valid_in = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    fill_pattern(1, 1024);
    for (int b = 0; b < BLK; b++) begin
      set_beat(b); tick();
      chk($sformatf("flush_quiet_%0d", b), valid_out, 0);
    end
    valid_in = 1'b0;
    check_drain("flush", 23);

    // Flush coinciding with a valid beat: that beat opens a new block
    fill_pattern(7, 0);
    for (int b = 0; b < 3; b++) begin
      set_beat(b); tick();
    end
    fill_pattern(1, 1024);
    flush = 1'b1; set_beat(0); tick(); flush = 1'b0;
    chk("flushv_quiet_0", valid_out, 0);
    for (int b = 1; b < BLK; b++) begin
      set_beat(b); tick();
      chk($sformatf("flushv_quiet_%0d", b), valid_out, 0);
    end
    valid_in = 1'b0;
    check_drain("flushv", 23);

    // Reset while beat 2 of a drain is on the outputs
    fill_pattern(1, 1024);
    send_block(1'b0);
    tick(); tick(); tick();
    chk("pre_rst_valid", valid_out, 1);
    chk("pre_rst_re0", real_out[0], 1024);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", valid_out, 0);
    chk("async_rst_sop", sop_out, 0);
    chk("async_rst_index", index_out, 0);
    chk("async_rst_re0", real_out[0], 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post_rst_quiet_%0d", k), valid_out, 0);
    end
    fill_pattern(1000, 2000);
    send_block(1'b0);
    check_drain("post_rst", 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
